// File: rtl/piano_pkg.sv
// Shared types and constants for the falling-tile game controller.
package piano_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int unsigned NUM_LANES_DFLT = 4;
  localparam int unsigned TILE_SIZE_DFLT = 75;
  localparam int unsigned Y_MAX_DFLT     = 479;

  localparam logic [7:0] KEY_SPACE = 8'h2C;

  // Keycode per lane, index = lane number (A, S, D, F)
  localparam logic [3:0][7:0] LANE_KEYS = {8'h09, 8'h07, 8'h16, 8'h04};

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every clock; loads seed on reset.
module lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic w_fb;

  assign w_fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= seed;
    end else begin
      q <= {q[6:0], w_fb};
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Game controller for four lane movers: spawns tiles, judges key hits,
// tracks score/lives/speed and the IDLE/PLAY/OVER game state.
module tile_scheduler
  import piano_pkg::*;
#(
  parameter int unsigned NUM_LANES      = NUM_LANES_DFLT,
  parameter int unsigned TILE_SIZE      = TILE_SIZE_DFLT,
  parameter int unsigned Y_MAX          = Y_MAX_DFLT,
  parameter int unsigned HIT_TOP        = 330,
  parameter int unsigned HIT_BOT        = 479,
  parameter int unsigned SPAWN_GAP      = 60,
  parameter int unsigned HITS_PER_LEVEL = 8,
  parameter int unsigned MAX_LIVES      = 3
) (
  input  logic                       frame_clk,
  input  logic                       Reset,
  input  logic [7:0]                 keycode,
  input  logic [NUM_LANES-1:0][9:0]  tile_y,
  output logic [NUM_LANES-1:0]       newNote,
  output logic [NUM_LANES-1:0]       kill,
  output logic [3:0]                 speed,
  output logic [15:0]                score,
  output logic [1:0]                 lives,
  output logic                       playing,
  output logic                       game_over
);

  localparam int unsigned HCW = $clog2(HITS_PER_LEVEL + 1);

  state_e                     r_state;
  logic [NUM_LANES-1:0]       r_active;
  logic [7:0]                 r_timer;
  logic [HCW-1:0]             r_hitcnt;
  logic [7:0]                 r_prev_key;
  logic [NUM_LANES-1:0]       r_new;
  logic [NUM_LANES-1:0]       r_kill;
  logic [3:0]                 r_speed;
  logic [15:0]                r_score;
  logic [1:0]                 r_lives;
  logic                       r_playing;
  logic                       r_game_over;

  logic [7:0]                 w_lfsr;
  logic [5:0]                 w_lfsr_unused;
  logic [1:0]                 w_cand;
  logic                       w_key_edge;
  logic                       w_space;
  logic                       w_key_vld;
  logic [1:0]                 w_key_lane;
  logic [NUM_LANES-1:0][10:0] w_bot;

  state_e                     w_state_nxt;
  logic [NUM_LANES-1:0]       w_active_nxt;
  logic [7:0]                 w_timer_nxt;
  logic [HCW-1:0]             w_hitcnt_nxt;
  logic [NUM_LANES-1:0]       w_new_nxt;
  logic [NUM_LANES-1:0]       w_kill_nxt;
  logic [3:0]                 w_speed_nxt;
  logic [15:0]                w_score_nxt;
  logic [1:0]                 w_lives_nxt;
  logic                       w_lose;
  logic                       w_hit_ok;
  logic                       w_found;
  logic [1:0]                 w_probe;

  lfsr8 u_lfsr (
    .clk   (frame_clk),
    .rst_n (Reset),
    .seed  (8'hA5),
    .q     (w_lfsr)
  );

  assign w_cand        = w_lfsr[1:0];
  assign w_lfsr_unused = w_lfsr[7:2];

  // Key press edge, lane key decode and tile bottom edges (11 bits, no wrap)
  always_comb begin
    w_key_edge = (keycode != r_prev_key) && (keycode != 8'h00);
    w_space    = w_key_edge && (keycode == KEY_SPACE);
    w_key_vld  = 1'b0;
    w_key_lane = 2'd0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      w_bot[i] = 11'(tile_y[i]) + 11'(TILE_SIZE);
      if (keycode == LANE_KEYS[i]) begin
        w_key_vld  = 1'b1;
        w_key_lane = 2'(i);
      end
    end
    w_hit_ok = r_active[w_key_lane]
               && (w_bot[w_key_lane] >= 11'(HIT_TOP))
               && ({1'b0, tile_y[w_key_lane]} <= 11'(HIT_BOT));
  end

  // Next-state: landing, key judge, speed-up, spawn, game-over
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_timer_nxt  = r_timer;
    w_hitcnt_nxt = r_hitcnt;
    w_new_nxt    = '0;
    w_kill_nxt   = '0;
    w_speed_nxt  = r_speed;
    w_score_nxt  = r_score;
    w_lives_nxt  = r_lives;
    w_lose       = 1'b0;
    w_found      = 1'b0;
    w_probe      = 2'd0;

    case (r_state)
      IDLE: begin
        if (w_space) begin
          w_state_nxt  = PLAY;
          w_score_nxt  = 16'd0;
          w_speed_nxt  = 4'd0;
          w_lives_nxt  = 2'(MAX_LIVES);
          w_timer_nxt  = 8'(SPAWN_GAP);
          w_hitcnt_nxt = '0;
          w_active_nxt = '0;
        end
      end

      OVER: begin
        if (w_space) begin
          w_state_nxt = IDLE;
        end
      end

      PLAY: begin
        for (int i = 0; i < int'(NUM_LANES); i++) begin
          if (r_active[i] && (w_bot[i] >= 11'(Y_MAX))) begin
            w_kill_nxt[i] = 1'b1;
            w_lose        = 1'b1;
          end
        end

        // A lane that landed this frame swallows its key press
        if (w_key_edge && w_key_vld && !w_kill_nxt[w_key_lane]) begin
          if (w_hit_ok) begin
            w_kill_nxt[w_key_lane] = 1'b1;
            w_hitcnt_nxt           = r_hitcnt + HCW'(1);
            if (r_score != 16'hFFFF) begin
              w_score_nxt = r_score + 16'd1;
            end
          end else begin
            w_lose = 1'b1;
          end
        end

        w_active_nxt = r_active & ~w_kill_nxt;

        if (w_hitcnt_nxt == HCW'(HITS_PER_LEVEL)) begin
          w_hitcnt_nxt = '0;
          if (r_speed != 4'd15) begin
            w_speed_nxt = r_speed + 4'd1;
          end
        end

        if (w_lose && (r_lives != 2'd0)) begin
          w_lives_nxt = r_lives - 2'd1;
        end

        if (w_lives_nxt == 2'd0) begin
          w_state_nxt  = OVER;
          w_kill_nxt   = w_kill_nxt | r_active;
          w_active_nxt = '0;
        end else begin
          w_timer_nxt = (r_timer == 8'd0) ? 8'd0 : (r_timer - 8'd1);
          if (w_timer_nxt == 8'd0) begin
            for (int p = 0; p < int'(NUM_LANES); p++) begin
              w_probe = w_cand + 2'(p);
              if (!w_found && !r_active[w_probe] && !w_kill_nxt[w_probe]) begin
                w_found               = 1'b1;
                w_new_nxt[w_probe]    = 1'b1;
                w_active_nxt[w_probe] = 1'b1;
                w_timer_nxt           = 8'(SPAWN_GAP) - {3'b000, w_speed_nxt, 1'b0};
              end
            end
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // All game state and registered outputs
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_active    <= '0;
      r_timer     <= 8'(SPAWN_GAP);
      r_hitcnt    <= '0;
      r_prev_key  <= 8'h00;
      r_new       <= '0;
      r_kill      <= '0;
      r_speed     <= 4'd0;
      r_score     <= 16'd0;
      r_lives     <= 2'(MAX_LIVES);
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_active    <= w_active_nxt;
      r_timer     <= w_timer_nxt;
      r_hitcnt    <= w_hitcnt_nxt;
      r_prev_key  <= keycode;
      r_new       <= w_new_nxt;
      r_kill      <= w_kill_nxt;
      r_speed     <= w_speed_nxt;
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_playing   <= (w_state_nxt == PLAY);
      r_game_over <= (w_state_nxt == OVER);
    end
  end

  assign newNote   = r_new;
  assign kill      = r_kill;
  assign speed     = r_speed;
  assign score     = r_score;
  assign lives     = r_lives;
  assign playing   = r_playing;
  assign game_over = r_game_over;

endmodule
